alu_sequencer: RTL and testbench
================================

# alu_sequencer

Request/response front-end for the 32-bit combinational ALU. It accepts one operation at a time from the datapath control (ALUOp plus funct) and decodes it to the ALU's 4-bit control code. It drives registered operands into the ALU instance, captures result and flags one cycle later, and holds them on a valid/ready response port. It acts as the initiator side of the ALU's operand/control interface and owns the clocked boundary the ALU itself lacks.

## Interface
- CNT_W, 16, width of the completed-operation counter
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  block can accept a request
- aluop_i  in  2  00 load/store add, 01 branch sub, 10 R-type (use funct), 11 illegal
- funct_i  in  6  R-type function field
- src1_i / src2_i  in  32  operands
- alu_rst_n_o  out  1  ALU reset, equals ~rst_i
- alu_src1_o / alu_src2_o  out  32  registered operands to ALU
- alu_ctrl_o  out  4  ALU control code
- alu_bonus_o  out  3  bonus control, constant 000
- alu_result_i  in  32  ALU result
- alu_zero_i / alu_cout_i / alu_overflow_i  in  1 each  ALU flags
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- rsp_result_o  out  32  captured result
- rsp_zero_o / rsp_cout_o / rsp_overflow_o  out  1 each  captured flags
- rsp_err_o  out  1  request was illegal
- op_count_o  out  CNT_W  count of responses transferred
- Reset is synchronous and active-high on rst_i. All state is clocked by clk_i.

## Operation
- FSM states:
  - IDLE: req_ready_o=1.
  - EXEC: operands are on the ALU.
  - RESP: rsp_valid_o=1.
- IDLE→EXEC on req_valid_i & req_ready_o with a legal decode. Operands and alu_ctrl_o are latched.
- IDLE→RESP on an accepted illegal decode. rsp_err_o=1, result and flags=0, ALU outputs unchanged.
- EXEC→RESP unconditionally. alu_result_i and the flags are registered at the end of EXEC.
- RESP→IDLE on rsp_ready_i. op_count_o increments by 1, wraps at 2^CNT_W−1→0. rsp_ready_i is ignored outside RESP.
- Decode:
  - aluop 00→0010 (add); 01→0110 (sub).
  - aluop 10 with funct 100000→0010 add, 100010→0110 sub, 100100→0000 and, 100101→0001 or, 100111→1100 nor, 101010→0111 slt.
  - Any other funct, or aluop 11, is illegal.
- Response fields stay stable while rsp_valid_o=1 and rsp_ready_i=0.
- rsp_err_o is cleared on the next legal response.

## Timing
- Reset values: state IDLE, req_ready_o=1, rsp_valid_o=0, all rsp_* =0, rsp_err_o=0, alu_src1_o=alu_src2_o=0, alu_ctrl_o=0000, op_count_o=0.
- Legal request accepted at edge T: EXEC during cycle T+1, rsp_valid_o high from T+2.
- Illegal request accepted at edge T: rsp_valid_o high from T+1.
- Minimum spacing between accepted legal requests is 3 cycles.
- Only one operation is outstanding. req_valid_i is ignored outside IDLE.
- rst_i mid-EXEC or mid-RESP aborts the operation: no response, counter cleared, IDLE next cycle.
- alu_rst_n_o is combinational from rst_i, so the ALU is held in reset in the same cycles.

## Test plan
- Reset, then idle 5 cycles -> req_ready_o=1, rsp_valid_o=0, op_count_o=0, alu_ctrl_o=0000.
- aluop=10, funct=100000, src1=0x7FFFFFFF, src2=1, rsp_ready_i=1 -> 2 cycles after accept: result 0x80000000, overflow=1, cout=0, zero=0, err=0, op_count_o=1.
- aluop=01, src1=src2=0x12345678 -> result 0, zero=1, cout=1, alu_ctrl_o=0110.
- aluop=10, funct=101010, src1=0xFFFFFFFF, src2=1, rsp_ready_i low 4 cycles -> result 1 held stable for all stalled cycles, then one transfer.
- aluop=10, funct=000000 -> rsp_valid_o one cycle after accept, err=1, result 0, alu_src*_o unchanged. A following legal add clears err.
- Accept a legal op, assert rst_i during EXEC -> no rsp_valid_o, op_count_o=0, req_ready_o=1 on the cycle after rst_i drops.

Source files
------------

// File: rtl/alu_sequencer.sv
// Request/response front-end for a 32-bit combinational ALU: decodes ALUOp/funct,
// registers operands into the ALU, captures result/flags and holds them on a valid/ready port.
module alu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       aluop_i,
    input  logic [5:0]       funct_i,
    input  logic [31:0]      src1_i,
    input  logic [31:0]      src2_i,
    output logic             alu_rst_n_o,
    output logic [31:0]      alu_src1_o,
    output logic [31:0]      alu_src2_o,
    output logic [3:0]       alu_ctrl_o,
    output logic [2:0]       alu_bonus_o,
    input  logic [31:0]      alu_result_i,
    input  logic             alu_zero_i,
    input  logic             alu_cout_i,
    input  logic             alu_overflow_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_result_o,
    output logic             rsp_zero_o,
    output logic             rsp_cout_o,
    output logic             rsp_overflow_o,
    output logic             rsp_err_o,
    output logic [CNT_W-1:0] op_count_o
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    state_t     state_nxt;
    logic       dec_legal;
    logic [3:0] dec_ctrl;
    logic       accept;

    // Returns {legal, ctrl}; illegal encodings report ctrl 0000.
    function automatic logic [4:0] decode(input logic [1:0] aluop, input logic [5:0] funct);
        logic [4:0] d;
        d = 5'b0_0000;
        case (aluop)
            2'b00: d = 5'b1_0010;
            2'b01: d = 5'b1_0110;
            2'b10: begin
                case (funct)
                    6'b100000: d = 5'b1_0010;
                    6'b100010: d = 5'b1_0110;
                    6'b100100: d = 5'b1_0000;
                    6'b100101: d = 5'b1_0001;
                    6'b100111: d = 5'b1_1100;
                    6'b101010: d = 5'b1_0111;
                    default:   d = 5'b0_0000;
                endcase
            end
            default: d = 5'b0_0000;
        endcase
        return d;
    endfunction

    assign {dec_legal, dec_ctrl} = decode(aluop_i, funct_i);
    assign accept      = req_valid_i && (state == IDLE);
    assign alu_rst_n_o = ~rst_i;
    assign alu_bonus_o = 3'b000;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = dec_legal ? EXEC : RESP;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP: begin
                if (rsp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state == IDLE);
        rsp_valid_o = (state == RESP);
    end

    // Operand/control stage: only a legal accept touches what the ALU sees.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alu_src1_o <= '0;
            alu_src2_o <= '0;
            alu_ctrl_o <= '0;
        end else if (accept && dec_legal) begin
            alu_src1_o <= src1_i;
            alu_src2_o <= src2_i;
            alu_ctrl_o <= dec_ctrl;
        end
    end

    // Response stage: captured at the end of EXEC, or zeroed with err on an illegal accept.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_result_o   <= '0;
            rsp_zero_o     <= 1'b0;
            rsp_cout_o     <= 1'b0;
            rsp_overflow_o <= 1'b0;
            rsp_err_o      <= 1'b0;
        end else if (state == EXEC) begin
            rsp_result_o   <= alu_result_i;
            rsp_zero_o     <= alu_zero_i;
            rsp_cout_o     <= alu_cout_i;
            rsp_overflow_o <= alu_overflow_i;
            rsp_err_o      <= 1'b0;
        end else if (accept && !dec_legal) begin
            rsp_result_o   <= '0;
            rsp_zero_o     <= 1'b0;
            rsp_cout_o     <= 1'b0;
            rsp_overflow_o <= 1'b0;
            rsp_err_o      <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_count_o <= '0;
        end else if (state == RESP && rsp_ready_i) begin
            op_count_o <= op_count_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: emulates the ALU, predicts every response
// from the operation semantics and checks handshake timing, stalls, errors and aborts.
module tb_alu_sequencer;

    localparam int TB_CNT_W = 4;

    typedef struct packed {
        logic        legal;
        logic [3:0]  ctrl;
        logic [31:0] result;
        logic        zero;
        logic        cout;
        logic        ov;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic [1:0]          aluop = '0;
    logic [5:0]          funct = '0;
    logic [31:0]         src1 = '0;
    logic [31:0]         src2 = '0;
    logic                alu_rst_n;
    logic [31:0]         alu_src1;
    logic [31:0]         alu_src2;
    logic [3:0]          alu_ctrl;
    logic [2:0]          alu_bonus;
    logic [31:0]         alu_result;
    logic                alu_zero;
    logic                alu_cout;
    logic                alu_overflow;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [31:0]         rsp_result;
    logic                rsp_zero;
    logic                rsp_cout;
    logic                rsp_overflow;
    logic                rsp_err;
    logic [TB_CNT_W-1:0] op_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [TB_CNT_W-1:0] exp_count = '0;
    logic [31:0]         last_src1 = '0;
    logic [31:0]         last_src2 = '0;
    logic [3:0]          last_ctrl = '0;

    alu_sequencer #(.CNT_W(TB_CNT_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .aluop_i        (aluop),
        .funct_i        (funct),
        .src1_i         (src1),
        .src2_i         (src2),
        .alu_rst_n_o    (alu_rst_n),
        .alu_src1_o     (alu_src1),
        .alu_src2_o     (alu_src2),
        .alu_ctrl_o     (alu_ctrl),
        .alu_bonus_o    (alu_bonus),
        .alu_result_i   (alu_result),
        .alu_zero_i     (alu_zero),
        .alu_cout_i     (alu_cout),
        .alu_overflow_i (alu_overflow),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_result_o   (rsp_result),
        .rsp_zero_o     (rsp_zero),
        .rsp_cout_o     (rsp_cout),
        .rsp_overflow_o (rsp_overflow),
        .rsp_err_o      (rsp_err),
        .op_count_o     (op_count)
    );

    always #5 clk = ~clk;

    // Combinational ALU stand-in, keyed on the control code, using wide signed arithmetic.
    longint ls_sum;
    longint ls_dif;
    always_comb begin
        ls_sum       = longint'($signed(alu_src1)) + longint'($signed(alu_src2));
        ls_dif       = longint'($signed(alu_src1)) - longint'($signed(alu_src2));
        alu_result   = 32'hDEAD_BEEF;
        alu_cout     = 1'b0;
        alu_overflow = 1'b0;
        case (alu_ctrl)
            4'b0010: begin
                alu_result   = alu_src1 + alu_src2;
                alu_cout     = (alu_result < alu_src1);
                alu_overflow = (ls_sum > 64'sd2147483647) || (ls_sum < -64'sd2147483648);
            end
            4'b0110, 4'b0111: begin
                alu_result   = (alu_ctrl == 4'b0111) ? ((ls_dif < 0) ? 32'd1 : 32'd0)
                                                     : alu_src1 - alu_src2;
                alu_cout     = (alu_src1 >= alu_src2);
                alu_overflow = (ls_dif > 64'sd2147483647) || (ls_dif < -64'sd2147483648);
            end
            4'b0000: alu_result = alu_src1 & alu_src2;
            4'b0001: alu_result = alu_src1 | alu_src2;
            4'b1100: alu_result = ~(alu_src1 | alu_src2);
            default: alu_result = 32'hDEAD_BEEF;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    // Reference: what a request should produce, from the instruction semantics.
    function automatic exp_t ref_op(input logic [1:0] op, input logic [5:0] fn,
                                    input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        int          kind;
        logic [32:0] s;
        logic [3:0]  codes [6];
        codes = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
        e = '0;
        kind = -1;
        if (op == 2'b00) kind = 0;
        else if (op == 2'b01) kind = 1;
        else if (op == 2'b10) begin
            case (fn)
                6'h20: kind = 0;
                6'h22: kind = 1;
                6'h24: kind = 2;
                6'h25: kind = 3;
                6'h27: kind = 4;
                6'h2A: kind = 5;
                default: kind = -1;
            endcase
        end
        if (kind < 0) return e;
        e.legal = 1'b1;
        e.ctrl  = codes[kind];
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        case (kind)
            0: begin
                s = {1'b0, a} + {1'b0, b};
                e.result = s[31:0];
                e.cout   = s[32];
                e.ov     = (a[31] == b[31]) && (s[31] != a[31]);
            end
            1, 5: begin
                e.cout   = s[32];
                e.ov     = (a[31] != b[31]) && (s[31] != a[31]);
                e.result = (kind == 1) ? s[31:0] : {31'd0, s[31] ^ e.ov};
            end
            2: e.result = a & b;
            3: e.result = a | b;
            default: e.result = ~(a | b);
        endcase
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    // Full transaction from IDLE back to IDLE, checking each cycle of the handshake.
    task automatic run_op(input logic [1:0] op, input logic [5:0] fn,
                          input logic [31:0] a, input logic [31:0] b, input int stall);
        exp_t e;
        e = ref_op(op, fn, a, b);
        req_valid = 1'b1; aluop = op; funct = fn; src1 = a; src2 = b;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++; $display("FAIL req_ready_idle: got %b want 1", req_ready);
        end
        @(posedge clk); #1;
        // Garbage request held during busy cycles must be ignored.
        aluop = 2'($urandom); funct = 6'($urandom); src1 = $urandom; src2 = $urandom;
        if (e.legal) begin
            last_src1 = a; last_src2 = b; last_ctrl = e.ctrl;
            rsp_ready = 1'($urandom);
            n_checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
                n_fail++; $display("FAIL exec_handshake: valid=%b ready=%b want 0 0", rsp_valid, req_ready);
            end
            n_checks++;
            if (alu_src1 !== a || alu_src2 !== b || alu_ctrl !== e.ctrl) begin
                n_fail++;
                $display("FAIL alu_drive: src1=%h src2=%h ctrl=%b want %h %h %b",
                         alu_src1, alu_src2, alu_ctrl, a, b, e.ctrl);
            end
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end else begin
            n_checks++;
            if (alu_src1 !== last_src1 || alu_src2 !== last_src2 || alu_ctrl !== last_ctrl) begin
                n_fail++;
                $display("FAIL alu_hold_illegal: src1=%h src2=%h ctrl=%b want %h %h %b",
                         alu_src1, alu_src2, alu_ctrl, last_src1, last_src2, last_ctrl);
            end
        end
        for (int i = 0; i <= stall; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
                n_fail++; $display("FAIL rsp_valid_cyc%0d: valid=%b ready=%b want 1 0", i, rsp_valid, req_ready);
            end
            n_checks++;
            if (rsp_result !== e.result || rsp_zero !== e.zero || rsp_cout !== e.cout ||
                rsp_overflow !== e.ov || rsp_err !== !e.legal) begin
                n_fail++;
                $display("FAIL rsp_fields_cyc%0d: res=%h z=%b c=%b v=%b err=%b want %h %b %b %b %b",
                         i, rsp_result, rsp_zero, rsp_cout, rsp_overflow, rsp_err,
                         e.result, e.zero, e.cout, e.ov, !e.legal);
            end
            if (i < stall) begin
                @(posedge clk); #1;
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        exp_count = exp_count + 1'b1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || op_count !== exp_count) begin
            n_fail++;
            $display("FAIL transfer: valid=%b ready=%b count=%0d want 0 1 %0d",
                     rsp_valid, req_ready, op_count, exp_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (alu_rst_n !== 1'b0) begin
            n_fail++; $display("FAIL alu_rst_n_in_reset: got %b want 0", alu_rst_n);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (alu_rst_n !== 1'b1 || alu_bonus !== 3'b000) begin
            n_fail++; $display("FAIL alu_rst_n_bonus: got %b %b want 1 000", alu_rst_n, alu_bonus);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || op_count !== '0 || alu_ctrl !== 4'b0000 ||
                alu_src1 !== '0 || alu_src2 !== '0 || rsp_result !== '0 || rsp_err !== 1'b0 ||
                rsp_zero !== 1'b0 || rsp_cout !== 1'b0 || rsp_overflow !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state: ready=%b valid=%b count=%0d ctrl=%b src=%h/%h res=%h err=%b want 1 0 0 0000 0/0 0 0",
                         req_ready, rsp_valid, op_count, alu_ctrl, alu_src1, alu_src2, rsp_result, rsp_err);
            end
        end
        exp_count = '0; last_src1 = '0; last_src2 = '0; last_ctrl = '0;
    endtask

    task automatic test_add_overflow();
        run_op(2'b10, 6'b100000, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        n_checks++;
        if (op_count !== TB_CNT_W'(1)) begin
            n_fail++; $display("FAIL add_first_count: got %0d want 1", op_count);
        end
    endtask

    task automatic test_sub_zero();
        run_op(2'b01, 6'($urandom), 32'h1234_5678, 32'h1234_5678, 0);
    endtask

    task automatic test_slt_stall();
        run_op(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'h0000_0001, 4);
    endtask

    task automatic test_illegal();
        run_op(2'b10, 6'b000000, 32'hAAAA_5555, 32'h5555_AAAA, 0);
        run_op(2'b11, 6'b100000, 32'h1, 32'h2, 2);
        run_op(2'b00, 6'b000000, 32'h0000_0010, 32'h0000_0020, 0);
    endtask

    task automatic test_abort(input bool_in_resp);
        run_op(2'b00, 6'b0, 32'h1, 32'h1, 0);
        req_valid = 1'b1; aluop = 2'b10; funct = 6'b100101; src1 = $urandom; src2 = $urandom;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (bool_in_resp) begin
            @(posedge clk); #1;
            rsp_ready = 1'b1;
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (alu_rst_n !== 1'b0) begin
            n_fail++; $display("FAIL abort_alu_rst_n: got %b want 0", alu_rst_n);
        end
        @(posedge clk); #1;
        rst = 1'b0; rsp_ready = 1'b0;
        exp_count = '0; last_src1 = '0; last_src2 = '0; last_ctrl = '0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || op_count !== '0) begin
                n_fail++;
                $display("FAIL abort_%0d_cyc%0d: valid=%b ready=%b count=%0d want 0 1 0",
                         bool_in_resp, i, rsp_valid, req_ready, op_count);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [5:0] legal_fn [6];
        logic [5:0] fn;
        legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        for (int k = 0; k < 40; k++) begin
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal_fn[$urandom_range(0, 5)];
            run_op(2'($urandom), fn,
                   ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom,
                   ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFF : $urandom,
                   $urandom_range(0, 3));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_zero();
        test_slt_stall();
        test_illegal();
        test_abort(1'b0);
        test_abort(1'b1);
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
